// File: rtl/dac_write_arbiter.sv
// dac_write_arbiter: round-robin commit of Soundrive and GS writes into the 4-channel DAC/volume registers.
// Optional DACARB_FIFO_EN: FIFO_DEPTH-entry queue per source instead of a single slot.
module dac_write_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk32,
  input  logic       rst_n,
  input  logic       sd_req,
  input  logic [1:0] sd_chn,
  input  logic [7:0] sd_data,
  input  logic       gs_req,
  input  logic       gs_vol,
  input  logic [1:0] gs_chn,
  input  logic [7:0] gs_data,
  input  logic       ovr_clr,
  output logic [7:0] dac0,
  output logic [7:0] dac1,
  output logic [7:0] dac2,
  output logic [7:0] dac3,
  output logic [5:0] vol0,
  output logic [5:0] vol1,
  output logic [5:0] vol2,
  output logic [5:0] vol3,
  output logic       sd_pend,
  output logic       gs_pend,
  output logic       sd_ovr,
  output logic       gs_ovr
);
  logic [1:0]  w_req, w_edge, w_ne, w_grant, w_push, w_drop;
  logic [10:0] w_in [2];
  logic [10:0] w_head [2];
  logic [10:0] w_h;
  logic [7:0]  w_conv;
  logic [1:0]  r_req_q, r_ovr;
  logic        r_rr;
  logic [7:0]  r_dac [4];
  logic [5:0]  r_vol [4];

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 8 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
    $error("FIFO_DEPTH must be a power of 2 in 2..8");

  // Index 0 is sd, index 1 is gs; entries are {vol, chn, data}
  assign w_req     = {gs_req, sd_req};
  assign w_edge    = w_req & ~r_req_q;
  assign w_in[0]   = {1'b0, sd_chn, sd_data};
  assign w_in[1]   = {gs_vol, gs_chn, gs_data};
  assign w_grant[0] = w_ne[0] & (~w_ne[1] | ~r_rr);
  assign w_grant[1] = w_ne[1] & ~w_grant[0];
  assign w_drop    = w_edge & ~w_push;

  for (genvar s = 0; s < 2; s++) begin : g_q
`ifdef DACARB_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [10:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_cnt;
    logic          w_full;
    assign w_full    = r_cnt == (AW+1)'(FIFO_DEPTH);
    assign w_ne[s]   = r_cnt != '0;
    assign w_head[s] = r_mem[r_rp];
    assign w_push[s] = w_edge[s] & (~w_full | w_grant[s]);
    always_ff @(posedge clk32)
      if (w_push[s]) r_mem[r_wp] <= w_in[s];
    always_ff @(posedge clk32 or negedge rst_n)
      if (!rst_n) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push[s]) r_wp <= r_wp + 1'b1;
        if (w_grant[s]) r_rp <= r_rp + 1'b1;
        r_cnt <= r_cnt + (AW+1)'(w_push[s]) - (AW+1)'(w_grant[s]);
      end
`else
    logic [10:0] r_slot;
    logic        r_v;
    assign w_ne[s]   = r_v;
    assign w_head[s] = r_slot;
    assign w_push[s] = w_edge[s] & (~r_v | w_grant[s]);
    always_ff @(posedge clk32 or negedge rst_n)
      if (!rst_n) begin
        r_v    <= 1'b0;
        r_slot <= '0;
      end else begin
        r_v <= w_push[s] | (r_v & ~w_grant[s]);
        if (w_push[s]) r_slot <= w_in[s];
      end
`endif
  end

  assign w_h    = w_grant[1] ? w_head[1] : w_head[0];
  assign w_conv = w_h[7] ? w_h[7:0] : {1'b0, ~w_h[6:0]};

  // req_q resets high so a request held through reset must drop before it counts
  always_ff @(posedge clk32 or negedge rst_n)
    if (!rst_n) begin
      r_req_q <= 2'b11;
      r_ovr   <= 2'b00;
      r_rr    <= 1'b0;
      r_dac   <= '{default: '0};
      r_vol   <= '{default: '0};
    end else begin
      r_req_q <= w_req;
      r_ovr   <= w_drop | (r_ovr & ~{2{ovr_clr}});
      if (&w_ne) r_rr <= ~r_rr;
      if ((|w_grant) & ~w_h[10]) r_dac[w_h[9:8]] <= w_conv;
      if (w_grant[0]) r_vol[w_h[9:8]] <= 6'h3F;
      else if (w_grant[1] & w_h[10]) r_vol[w_h[9:8]] <= w_h[5:0];
    end

  assign dac0    = r_dac[0];
  assign dac1    = r_dac[1];
  assign dac2    = r_dac[2];
  assign dac3    = r_dac[3];
  assign vol0    = r_vol[0];
  assign vol1    = r_vol[1];
  assign vol2    = r_vol[2];
  assign vol3    = r_vol[3];
  assign sd_pend = w_ne[0];
  assign gs_pend = w_ne[1];
  assign sd_ovr  = r_ovr[0];
  assign gs_ovr  = r_ovr[1];
endmodule

// File: tb/tb_dac_write_arbiter.sv
// tb_dac_write_arbiter: directed and random checks of dac_write_arbiter against a queue-based reference model.
module tb_dac_write_arbiter;
  logic       clk32 = 1'b0;
  logic       rst_n = 1'b0;
  logic       sd_req = 1'b0, gs_req = 1'b0, gs_vol = 1'b0, ovr_clr = 1'b0;
  logic [1:0] sd_chn = '0, gs_chn = '0;
  logic [7:0] sd_data = '0, gs_data = '0;
  logic [7:0] dac0, dac1, dac2, dac3;
  logic [5:0] vol0, vol1, vol2, vol3;
  logic       sd_pend, gs_pend, sd_ovr, gs_ovr;
  int         checks = 0;
  int         errors = 0;

`ifdef DACARB_FIFO_EN
  localparam int D = 4;
`else
  localparam int D = 1;
`endif

  always #5 clk32 = ~clk32;

  dac_write_arbiter #(.FIFO_DEPTH(4)) dut (
    .clk32(clk32), .rst_n(rst_n),
    .sd_req(sd_req), .sd_chn(sd_chn), .sd_data(sd_data),
    .gs_req(gs_req), .gs_vol(gs_vol), .gs_chn(gs_chn), .gs_data(gs_data),
    .ovr_clr(ovr_clr),
    .dac0(dac0), .dac1(dac1), .dac2(dac2), .dac3(dac3),
    .vol0(vol0), .vol1(vol1), .vol2(vol2), .vol3(vol3),
    .sd_pend(sd_pend), .gs_pend(gs_pend), .sd_ovr(sd_ovr), .gs_ovr(gs_ovr)
  );

  // Reference model: per-source queues of {vol, chn, data}, register file, turn flag
  logic [10:0] q_sd[$];
  logic [10:0] q_gs[$];
  bit          m_low_sd, m_low_gs, m_turn_gs, m_ovr_sd, m_ovr_gs;
  logic [7:0]  m_dac [4];
  logic [5:0]  m_vol [4];

  function automatic logic [7:0] cv(input logic [7:0] x);
    return (x >= 8'd128) ? x : 8'd127 - x;
  endfunction

  task automatic model_reset();
    q_sd.delete();
    q_gs.delete();
    m_low_sd = 0;
    m_low_gs = 0;
    m_turn_gs = 0;
    m_ovr_sd = 0;
    m_ovr_gs = 0;
    for (int i = 0; i < 4; i++) begin
      m_dac[i] = 8'h00;
      m_vol[i] = 6'h00;
    end
  endtask

  task automatic model_step();
    logic [10:0] e;
    bit has_sd, has_gs, take_sd, take_gs;
    has_sd = q_sd.size() != 0;
    has_gs = q_gs.size() != 0;
    take_sd = has_sd && (!has_gs || !m_turn_gs);
    take_gs = has_gs && !take_sd;
    if (has_sd && has_gs) m_turn_gs = !m_turn_gs;
    if (take_sd) begin
      e = q_sd.pop_front();
      m_dac[e[9:8]] = cv(e[7:0]);
      m_vol[e[9:8]] = 6'h3F;
    end
    if (take_gs) begin
      e = q_gs.pop_front();
      if (e[10]) m_vol[e[9:8]] = e[5:0];
      else m_dac[e[9:8]] = cv(e[7:0]);
    end
    if (ovr_clr) begin
      m_ovr_sd = 0;
      m_ovr_gs = 0;
    end
    if (sd_req && m_low_sd) begin
      if (q_sd.size() < D) q_sd.push_back({1'b0, sd_chn, sd_data});
      else m_ovr_sd = 1;
    end
    if (gs_req && m_low_gs) begin
      if (q_gs.size() < D) q_gs.push_back({gs_vol, gs_chn, gs_data});
      else m_ovr_gs = 1;
    end
    m_low_sd = !sd_req;
    m_low_gs = !gs_req;
  endtask

  function automatic logic [59:0] exp_vec();
    return {m_dac[0], m_dac[1], m_dac[2], m_dac[3], m_vol[0], m_vol[1], m_vol[2], m_vol[3],
            q_sd.size() != 0, q_gs.size() != 0, m_ovr_sd, m_ovr_gs};
  endfunction

  function automatic logic [59:0] act_vec();
    return {dac0, dac1, dac2, dac3, vol0, vol1, vol2, vol3, sd_pend, gs_pend, sd_ovr, gs_ovr};
  endfunction

  task automatic tick();
    if (!rst_n) model_reset();
    else model_step();
    @(posedge clk32);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    sd_req = 1;
    repeat (5) tick();
    checks++;
    if (act_vec() !== 60'h0) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", act_vec(), 60'h0);
    end
    rst_n = 1;
    repeat (3) tick();
    checks++;
    if (act_vec() !== 60'h0) begin
      errors++;
      $display("FAIL held_req_no_edge: got %h expected %h", act_vec(), 60'h0);
    end
    checks++;
    if (act_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_model: got %h expected %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_single_sd();
    sd_req = 0;
    tick();
    sd_chn = 2;
    sd_data = 8'h05;
    sd_req = 1;
    tick();
    checks++;
    if (sd_pend !== 1'b1) begin
      errors++;
      $display("FAIL sd_pend_after_edge: got %b expected 1", sd_pend);
    end
    tick();
    checks++;
    if ({dac2, vol2} !== {8'h7A, 6'h3F}) begin
      errors++;
      $display("FAIL sd_write_ch2: got %h expected %h", {dac2, vol2}, {8'h7A, 6'h3F});
    end
    checks++;
    if ({dac0, dac1, dac3, vol0, vol1, vol3, sd_pend} !== 43'h0) begin
      errors++;
      $display("FAIL sd_other_channels: got %h expected 0", {dac0, dac1, dac3, vol0, vol1, vol3, sd_pend});
    end
  endtask

  task automatic test_conv();
    sd_req = 0;
    gs_vol = 0;
    gs_chn = 1;
    gs_data = 8'hC3;
    gs_req = 1;
    repeat (2) tick();
    checks++;
    if (dac1 !== 8'hC3) begin
      errors++;
      $display("FAIL gs_dac_positive: got %h expected %h", dac1, 8'hC3);
    end
    gs_req = 0;
    tick();
    gs_vol = 1;
    gs_data = 8'hFF;
    gs_req = 1;
    repeat (2) tick();
    checks++;
    if ({dac1, vol1} !== {8'hC3, 6'h3F}) begin
      errors++;
      $display("FAIL gs_vol_write: got %h expected %h", {dac1, vol1}, {8'hC3, 6'h3F});
    end
    checks++;
    if (act_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL conv_model: got %h expected %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_round_robin();
    sd_req = 0;
    gs_req = 0;
    gs_vol = 0;
    tick();
    sd_chn = 0;
    gs_chn = 0;
    sd_data = 8'h80;
    gs_data = 8'h10;
    sd_req = 1;
    gs_req = 1;
    repeat (2) tick();
    checks++;
    if ({dac0, gs_pend} !== {8'h80, 1'b1}) begin
      errors++;
      $display("FAIL rr_sd_first: got %h expected %h", {dac0, gs_pend}, {8'h80, 1'b1});
    end
    tick();
    checks++;
    if (dac0 !== 8'h6F) begin
      errors++;
      $display("FAIL rr_gs_second: got %h expected %h", dac0, 8'h6F);
    end
    sd_req = 0;
    gs_req = 0;
    tick();
    sd_data = 8'h20;
    gs_data = 8'h90;
    sd_req = 1;
    gs_req = 1;
    repeat (2) tick();
    checks++;
    if ({dac0, sd_pend} !== {8'h90, 1'b1}) begin
      errors++;
      $display("FAIL rr_gs_first: got %h expected %h", {dac0, sd_pend}, {8'h90, 1'b1});
    end
    tick();
    checks++;
    if ({dac0, vol0} !== {8'h5F, 6'h3F}) begin
      errors++;
      $display("FAIL rr_sd_second: got %h expected %h", {dac0, vol0}, {8'h5F, 6'h3F});
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 24; i++) begin
      sd_req = i[0];
      gs_req = i[0];
      sd_chn = 2'(i);
      gs_chn = 2'(i + 1);
      sd_data = 8'($urandom);
      gs_data = 8'($urandom);
      gs_vol = 1'($urandom);
      tick();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL overflow_stress: cycle %0d got %h expected %h", i, act_vec(), exp_vec());
      end
    end
    ovr_clr = 1;
    tick();
    ovr_clr = 0;
    checks++;
    if ({sd_ovr, gs_ovr} !== 2'b00) begin
      errors++;
      $display("FAIL ovr_clr: got %b expected 00", {sd_ovr, gs_ovr});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      sd_req = 1'($urandom_range(0, 1));
      gs_req = 1'($urandom_range(0, 1));
      sd_chn = 2'($urandom);
      gs_chn = 2'($urandom);
      sd_data = 8'($urandom);
      gs_data = 8'($urandom);
      gs_vol = 1'($urandom);
      ovr_clr = ($urandom_range(0, 7) == 0);
      tick();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random: cycle %0d got %h expected %h", i, act_vec(), exp_vec());
      end
    end
    ovr_clr = 0;
  endtask

  task automatic test_reset_mid();
    sd_req = 0;
    gs_req = 0;
    tick();
    sd_chn = 3;
    gs_chn = 3;
    sd_data = 8'h44;
    gs_data = 8'h55;
    gs_vol = 0;
    sd_req = 1;
    gs_req = 1;
    tick();
    checks++;
    if ({sd_pend, gs_pend} !== 2'b11) begin
      errors++;
      $display("FAIL mid_both_pending: got %b expected 11", {sd_pend, gs_pend});
    end
    #2 rst_n = 0;
    #1;
    model_reset();
    checks++;
    if (act_vec() !== 60'h0) begin
      errors++;
      $display("FAIL mid_async_clear: got %h expected %h", act_vec(), 60'h0);
    end
    tick();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (act_vec() !== 60'h0 || exp_vec() !== 60'h0) begin
        errors++;
        $display("FAIL mid_no_stale_commit: cycle %0d got %h expected %h", i, act_vec(), 60'h0);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_sd();
    test_conv();
    test_round_robin();
    test_overflow();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
